// File: rtl/sram_seq_pkg.sv
// Shared types and constants for the word-to-byte SRAM sequencer.
package sram_seq_pkg;

  localparam int BYTES_PER_WORD = 4;
  localparam int SRAM_DATA_W    = 8;

  typedef logic [1:0] lane_t;
  typedef logic [2:0] state_t;

  localparam state_t IDLE      = 3'd0;
  localparam state_t WRITE     = 3'd1;
  localparam state_t READ      = 3'd2;
  localparam state_t READ_WAIT = 3'd3;
  localparam state_t DONE      = 3'd4;

  function automatic logic [BYTES_PER_WORD-1:0] lane_bit(input lane_t l);
    logic [BYTES_PER_WORD-1:0] m;
    m    = '0;
    m[l] = 1'b1;
    return m;
  endfunction

endpackage

// File: rtl/sram_rd_lat_pipe.sv
// Delays each issued read lane tag by the macro read latency so the returning
// byte can be steered into the right slot of the assembly word.
module sram_rd_lat_pipe
  import sram_seq_pkg::*;
#(
  parameter int RD_LAT = 1
) (
  input  logic  clk,
  input  logic  rst,
  input  logic  issue_valid,
  input  lane_t issue_lane,
  output logic  cap_valid,
  output lane_t cap_lane
);

  logic [RD_LAT-1:0] vld_sr;
  lane_t             lane_sr [RD_LAT];

  always_ff @(posedge clk) begin
    if (rst) begin
      vld_sr <= '0;
      for (int i = 0; i < RD_LAT; i++) begin
        lane_sr[i] <= '0;
      end
    end else begin
      vld_sr[0]  <= issue_valid;
      lane_sr[0] <= issue_lane;
      for (int i = 1; i < RD_LAT; i++) begin
        vld_sr[i]  <= vld_sr[i-1];
        lane_sr[i] <= lane_sr[i-1];
      end
    end
  end

  assign cap_valid = vld_sr[RD_LAT-1];
  assign cap_lane  = lane_sr[RD_LAT-1];

endmodule

// File: rtl/sram_word_sequencer.sv
// Bridges the picorv32 32-bit native memory port onto an 8-bit OpenRAM macro,
// splitting each access into four byte cycles and returning a one-cycle ready.
module sram_word_sequencer
  import sram_seq_pkg::*;
#(
  parameter int ADDR_W = 10,
  parameter int RD_LAT = 1
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   mem_valid,
  input  logic                   mem_instr,
  input  logic [31:0]            mem_addr,
  input  logic [31:0]            mem_wdata,
  input  logic [3:0]             mem_wstrb,
  output logic                   mem_ready,
  output logic [31:0]            mem_rdata,
  output logic                   sram_csb0,
  output logic                   sram_web0,
  output logic [ADDR_W-1:0]      sram_addr0,
  output logic [SRAM_DATA_W-1:0] sram_din0,
  input  logic [SRAM_DATA_W-1:0] sram_dout0
);

  state_t                    state;
  lane_t                     lane;
  logic [ADDR_W-3:0]         word_addr;
  logic [31:0]               wdata_q;
  logic [BYTES_PER_WORD-1:0] wstrb_q;
  logic [31:0]               asm_word;
  logic [BYTES_PER_WORD-1:0] got_mask;
  logic [BYTES_PER_WORD-1:0] got_next;
  logic                      issue_rd;
  logic                      cap_valid;
  lane_t                     cap_lane;
  logic                      accept;
  logic                      unused_bits;

  // Word-offset and out-of-range address bits are dropped, so addresses alias.
  assign unused_bits = ^{mem_instr, mem_addr[31:ADDR_W], mem_addr[1:0]};

  assign accept   = (state == IDLE) && mem_valid;
  assign issue_rd = (state == READ);

  sram_rd_lat_pipe #(
    .RD_LAT (RD_LAT)
  ) u_rd_lat_pipe (
    .clk         (clk),
    .rst         (rst),
    .issue_valid (issue_rd),
    .issue_lane  (lane),
    .cap_valid   (cap_valid),
    .cap_lane    (cap_lane)
  );

  always_comb begin
    got_next = got_mask;
    if (cap_valid) begin
      got_next = got_mask | lane_bit(cap_lane);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      asm_word <= '0;
      got_mask <= '0;
    end else if (accept) begin
      asm_word <= '0;
      got_mask <= '0;
    end else if (cap_valid) begin
      asm_word[{cap_lane, 3'b000} +: SRAM_DATA_W] <= sram_dout0;
      got_mask <= got_next;
    end
  end

  // Macro strobes default to idle each cycle; only WRITE/READ pull them low.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      lane       <= '0;
      word_addr  <= '0;
      wdata_q    <= '0;
      wstrb_q    <= '0;
      mem_ready  <= 1'b0;
      mem_rdata  <= '0;
      sram_csb0  <= 1'b1;
      sram_web0  <= 1'b1;
      sram_addr0 <= '0;
      sram_din0  <= '0;
    end else begin
      mem_ready <= 1'b0;
      mem_rdata <= '0;
      sram_csb0 <= 1'b1;
      sram_web0 <= 1'b1;
      case (state)
        IDLE: begin
          if (mem_valid) begin
            word_addr <= mem_addr[ADDR_W-1:2];
            wdata_q   <= mem_wdata;
            wstrb_q   <= mem_wstrb;
            lane      <= '0;
            state     <= (mem_wstrb != 4'h0) ? WRITE : READ;
          end
        end
        WRITE: begin
          // Disabled lanes still take their slot so write latency is fixed.
          sram_addr0 <= {word_addr, lane};
          sram_din0  <= wdata_q[{lane, 3'b000} +: SRAM_DATA_W];
          sram_web0  <= 1'b0;
          sram_csb0  <= ~wstrb_q[lane];
          lane       <= lane + 2'd1;
          if (lane == 2'd3) begin
            state <= DONE;
          end
        end
        READ: begin
          sram_addr0 <= {word_addr, lane};
          sram_csb0  <= 1'b0;
          lane       <= lane + 2'd1;
          if (lane == 2'd3) begin
            state <= READ_WAIT;
          end
        end
        READ_WAIT: begin
          if (got_next == '1) begin
            state <= DONE;
          end
        end
        DONE: begin
          mem_ready <= 1'b1;
          mem_rdata <= (wstrb_q != 4'h0) ? 32'h0 : asm_word;
          state     <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sram_word_sequencer.sv
// Directed bench driving two sequencers (read latency 1 and 2) with shared CPU
// stimulus, each backed by its own byte-wide memory model.
module tb_sram_word_sequencer;

  logic        clk = 1'b0;
  logic        rst;
  logic        mem_valid;
  logic        mem_instr;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_wstrb;

  logic        rdy1, rdy2;
  logic [31:0] rdata1, rdata2;
  logic        csb1, web1, csb2, web2;
  logic [9:0]  addr1, addr2;
  logic [7:0]  din1, din2, dout1, dout2;

  logic [7:0]  mem1 [1024];
  logic [7:0]  mem2 [1024];

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic [31:0] exp_rdata;
  } vec_t;

  vec_t vecs [12];

  always #5 clk = ~clk;

  sram_word_sequencer #(.ADDR_W(10), .RD_LAT(1)) dut1 (
    .clk        (clk),
    .rst        (rst),
    .mem_valid  (mem_valid),
    .mem_instr  (mem_instr),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_wstrb  (mem_wstrb),
    .mem_ready  (rdy1),
    .mem_rdata  (rdata1),
    .sram_csb0  (csb1),
    .sram_web0  (web1),
    .sram_addr0 (addr1),
    .sram_din0  (din1),
    .sram_dout0 (dout1)
  );

  sram_word_sequencer #(.ADDR_W(10), .RD_LAT(2)) dut2 (
    .clk        (clk),
    .rst        (rst),
    .mem_valid  (mem_valid),
    .mem_instr  (mem_instr),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_wstrb  (mem_wstrb),
    .mem_ready  (rdy2),
    .mem_rdata  (rdata2),
    .sram_csb0  (csb2),
    .sram_web0  (web2),
    .sram_addr0 (addr2),
    .sram_din0  (din2),
    .sram_dout0 (dout2)
  );

  // Latency 1: data visible in the same cycle the read is presented.
  assign dout1 = (!csb1 && web1) ? mem1[addr1] : 8'h00;

  // Latency 2: data registered at the sampling edge, visible one cycle later.
  always @(posedge clk) begin
    if (!csb1 && !web1) mem1[addr1] <= din1;
    if (!csb2 && !web2) mem2[addr2] <= din2;
    if (!csb2 && web2)  dout2 <= mem2[addr2];
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic checkIdle(input string tag);
    checkOutput({tag, " ready1"}, 32'(rdy1), 32'h0);
    checkOutput({tag, " rdata1"}, rdata1, 32'h0);
    checkOutput({tag, " csb1"}, 32'(csb1), 32'h1);
    checkOutput({tag, " web1"}, 32'(web1), 32'h1);
    checkOutput({tag, " addr1"}, 32'(addr1), 32'h0);
    checkOutput({tag, " din1"}, 32'(din1), 32'h0);
    checkOutput({tag, " ready2"}, 32'(rdy2), 32'h0);
    checkOutput({tag, " csb2"}, 32'(csb2), 32'h1);
  endtask

  task automatic applyStimulus(input vec_t v, input int idx);
    int          first1, first2, pulses1, pulses2;
    logic [31:0] got1, got2;
    logic [9:0]  log_addr [8];
    logic [7:0]  log_din [8];
    logic        log_web [8];
    int          log_cyc [8];
    int          log_n, e, exp_lat1, exp_lat2;
    bit          is_wr;

    is_wr    = (v.wstrb != 4'h0);
    exp_lat1 = is_wr ? 5 : 6;
    exp_lat2 = is_wr ? 5 : 7;
    first1 = -1; first2 = -1; pulses1 = 0; pulses2 = 0;
    got1 = '0; got2 = '0; log_n = 0;

    @(negedge clk);
    mem_valid = 1'b1;
    mem_instr = !is_wr;
    mem_addr  = v.addr;
    mem_wdata = v.wdata;
    mem_wstrb = v.wstrb;
    @(posedge clk);
    #1;
    mem_valid = 1'b0;
    mem_addr  = 32'hFFFF_FFFF;
    mem_wdata = 32'h5A5A_5A5A;
    mem_wstrb = is_wr ? 4'h0 : 4'hF;

    for (int n = 1; n <= 12; n++) begin
      @(posedge clk);
      @(negedge clk);
      if (rdy1) begin
        pulses1++;
        if (first1 < 0) begin first1 = n; got1 = rdata1; end
      end
      if (rdy2) begin
        pulses2++;
        if (first2 < 0) begin first2 = n; got2 = rdata2; end
      end
      if (!csb1) begin
        if (log_n < 8) begin
          log_addr[log_n] = addr1;
          log_din[log_n]  = din1;
          log_web[log_n]  = web1;
          log_cyc[log_n]  = n;
        end
        log_n++;
      end
    end

    checkOutput($sformatf("v%0d latency lat1", idx), 32'(first1), 32'(exp_lat1));
    checkOutput($sformatf("v%0d latency lat2", idx), 32'(first2), 32'(exp_lat2));
    checkOutput($sformatf("v%0d ready width lat1", idx), 32'(pulses1), 32'h1);
    checkOutput($sformatf("v%0d ready width lat2", idx), 32'(pulses2), 32'h1);
    checkOutput($sformatf("v%0d rdata lat1", idx), got1, v.exp_rdata);
    checkOutput($sformatf("v%0d rdata lat2", idx), got2, v.exp_rdata);

    e = 0;
    for (int ln = 0; ln < 4; ln++) begin
      if (is_wr && !v.wstrb[ln]) continue;
      if (e < log_n && e < 8) begin
        checkOutput($sformatf("v%0d macro addr #%0d", idx, e), 32'(log_addr[e]),
                    32'({v.addr[9:2], 2'(ln)}));
        checkOutput($sformatf("v%0d macro cycle #%0d", idx, e), 32'(log_cyc[e]), 32'(ln + 1));
        checkOutput($sformatf("v%0d macro web #%0d", idx, e), 32'(log_web[e]), 32'(!is_wr));
        if (is_wr) begin
          checkOutput($sformatf("v%0d macro din #%0d", idx, e), 32'(log_din[e]),
                      32'(v.wdata[ln*8 +: 8]));
        end
      end
      e++;
    end
    checkOutput($sformatf("v%0d macro active cycles", idx), 32'(log_n), 32'(e));
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int quiet;

    vecs[0]  = '{32'h0000_0010, 32'hDEAD_BEEF, 4'hF, 32'h0000_0000};
    vecs[1]  = '{32'h0000_0010, 32'h0000_0000, 4'h0, 32'hDEAD_BEEF};
    vecs[2]  = '{32'h0000_0010, 32'h0055_0000, 4'h4, 32'h0000_0000};
    vecs[3]  = '{32'h0000_0010, 32'h0000_0000, 4'h0, 32'hDE55_BEEF};
    vecs[4]  = '{32'h0000_0410, 32'h0000_0000, 4'h0, 32'hDE55_BEEF};
    vecs[5]  = '{32'h0000_0013, 32'h0000_0000, 4'h0, 32'hDE55_BEEF};
    vecs[6]  = '{32'h0000_03FC, 32'h0000_0000, 4'hF, 32'h0000_0000};
    vecs[7]  = '{32'h0000_03FC, 32'h1122_3344, 4'h9, 32'h0000_0000};
    vecs[8]  = '{32'h0000_03FC, 32'h0000_0000, 4'h0, 32'h1100_0044};
    vecs[9]  = '{32'hFFFF_FC20, 32'hAABB_CCDD, 4'hF, 32'h0000_0000};
    vecs[10] = '{32'h0000_0020, 32'h1111_2222, 4'h3, 32'h0000_0000};
    vecs[11] = '{32'h0000_0020, 32'h0000_0000, 4'h0, 32'hAABB_2222};

    rst       = 1'b1;
    mem_valid = 1'b1;
    mem_instr = 1'b0;
    mem_addr  = 32'h0000_0010;
    mem_wdata = 32'hFFFF_FFFF;
    mem_wstrb = 4'hF;

    $display("[TB] reset with a pending request");
    repeat (2) begin
      @(posedge clk);
      @(negedge clk);
      checkIdle("reset");
    end
    rst       = 1'b0;
    mem_valid = 1'b0;
    @(posedge clk);
    @(negedge clk);
    checkIdle("post-reset");

    $display("[TB] directed vector table");
    for (int i = 0; i < 12; i++) begin
      applyStimulus(vecs[i], i);
    end

    $display("[TB] reset during lane 2 read issue");
    @(negedge clk);
    mem_valid = 1'b1;
    mem_instr = 1'b1;
    mem_addr  = 32'h0000_0010;
    mem_wstrb = 4'h0;
    @(posedge clk);
    #1;
    mem_valid = 1'b0;
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    checkOutput("abort csb1", 32'(csb1), 32'h1);
    checkOutput("abort csb2", 32'(csb2), 32'h1);
    checkOutput("abort ready1", 32'(rdy1), 32'h0);
    rst   = 1'b0;
    quiet = 0;
    for (int n = 0; n < 10; n++) begin
      @(posedge clk);
      @(negedge clk);
      if (rdy1 || rdy2 || !csb1 || !csb2) quiet++;
    end
    checkOutput("abort stays idle", 32'(quiet), 32'h0);
    applyStimulus('{32'h0000_0010, 32'h0, 4'h0, 32'hDE55_BEEF}, 99);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/sram_word_sequencer.md
Name: sram_word_sequencer

Overview:
Sits between the picorv32 native memory port and the 8-bit OpenRAM macro (sram_8_1024_sky130A).
- Splits each 32-bit CPU access into up to four byte-wide SRAM cycles.
- Honours mem_wstrb per byte lane.
- Assembles read bytes into a 32-bit word, accounting for the macro's read latency.
- Returns a single-cycle mem_ready pulse.

Parameters:
ADDR_W, 10, SRAM byte-address width (1024 bytes)
RD_LAT, 1, cycles from a sampled read cycle (csb0=0, web0=1) to valid sram_dout0

Ports:
clk  in  1  system clock, rising edge
rst  in  1  synchronous, active-high reset
mem_valid  in  1  CPU request valid
mem_instr  in  1  instruction fetch flag (informational, no behavioural effect)
mem_addr  in  32  CPU byte address; bits [1:0] ignored; bits above ADDR_W ignored (aliasing)
mem_wdata  in  32  write data, lane n = bits [8n+7:8n]
mem_wstrb  in  4  byte write strobes; 0 = read
mem_ready  out  1  one-cycle completion pulse
mem_rdata  out  32  read data, valid while mem_ready=1
sram_csb0  out  1  macro chip select, active low
sram_web0  out  1  macro write enable, active low
sram_addr0  out  ADDR_W  macro byte address
sram_din0  out  8  macro write data
sram_dout0  in  8  macro read data

Behaviour:
- Reset: state IDLE; mem_ready=0, mem_rdata=0, sram_csb0=1, sram_web0=1, sram_addr0=0, sram_din0=0.
- All macro outputs are registered; driven values apply from the cycle after the state update.
- IDLE: on mem_valid=1, latch addr/wdata/wstrb.
  - wstrb!=0: go to WRITE.
  - Otherwise go to READ.
  - Lane counter lane=0.
- WRITE, 4 cycles, lane 0..3:
  - sram_addr0 = {mem_addr[ADDR_W-1:2], lane[1:0]}; sram_din0 = lane byte; sram_web0=0.
  - sram_csb0 = ~wstrb[lane]; disabled lanes cost a cycle but do not touch the macro.
  - After lane 3, go to DONE.
- READ, 4 cycles: issue lanes 0..3 with csb0=0, web0=1.
  - Each issued lane tag is delayed RD_LAT cycles.
  - The returning sram_dout0 is written into byte tag of an internal 32-bit assembly register.
  - Stay in READ_WAIT until all 4 bytes have returned, then go to DONE.
- DONE: mem_ready=1 for exactly one cycle.
  - mem_rdata = assembled word for reads; mem_rdata = 0 for writes.
  - Next state is IDLE; csb0=1, web0=1 in DONE and IDLE.
- Latency from the acceptance edge to mem_ready high: write 5 cycles; read 4+RD_LAT+1 cycles (6 at default).
- mem_valid is not re-sampled in DONE. The CPU drops mem_valid on the ready edge, so IDLE never double-accepts.
- mem_valid dropping mid-transaction: the transaction completes anyway.
- Input changes mid-transaction are ignored (latched copy is used).
- rst mid-operation: the next edge returns to IDLE with reset values.
  - The transaction is abandoned and no mem_ready is issued.
  - In-flight read tags are flushed.
- No back-to-back overlap: at most one transaction in flight.

Decomposition:
- Package sram_seq_pkg:
  - state enum {IDLE, WRITE, READ, READ_WAIT, DONE}
  - BYTES_PER_WORD=4
  - lane_t (2-bit)
  - SRAM_DATA_W=8
- One sub-module, sram_rd_lat_pipe:
  - RD_LAT-deep shift of {valid, lane_t}, cleared by rst.
  - Outputs the capture strobe and lane index.

Test Plan:
- Reset: assert rst 2 cycles with mem_valid=1 -> mem_ready=0, mem_rdata=0, csb0=1, web0=1 throughout and the cycle after release if mem_valid=0.
- Full write: addr 0x00000010, wdata 0xDEADBEEF, wstrb 0xF.
  - Required: macro writes 0x010=EF, 0x011=BE, 0x012=AD, 0x013=DE on 4 consecutive cycles.
  - Required: mem_ready pulses 5 cycles after acceptance, width 1.
- Read back addr 0x00000010, wstrb 0 -> mem_rdata=0xDEADBEEF with mem_ready 6 cycles after acceptance (RD_LAT=1); also run with RD_LAT=2 -> 7 cycles.
- Partial write: addr 0x10, wstrb 0x4, wdata 0x00550000.
  - Required: csb0 low only for addr 0x012.
  - Required: subsequent read returns 0xDE55BEEF.
- Alias: read addr 0x00000410 -> sram_addr0 sequence 0x010..0x013, mem_rdata=0xDE55BEEF.
- Reset mid-read: assert rst during lane 2 issue.
  - Required: csb0=1 next cycle, no mem_ready.
  - Required: a following read of 0x10 returns 0xDE55BEEF at normal latency.
